// File: rtl/cam_pkg.sv
// cam_pkg: shared types and default sizing for the CAM lookup controller.
//   cam_ctrl_state_t : controller FSM states
//   CAM_WIDTH        : default key / CAM data width
//   CAM_ADDR_WIDTH   : default CAM index width
//   CAM_HEIGHT       : default number of CAM entries (<= 2**CAM_ADDR_WIDTH)
package cam_pkg;

    localparam int CAM_WIDTH      = 32;
    localparam int CAM_ADDR_WIDTH = 5;
    localparam int CAM_HEIGHT     = 32;

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        WAIT,
        WRITE,
        RESP
    } cam_ctrl_state_t;

endpackage

// File: rtl/cam_alloc_ptr.sv
// cam_alloc_ptr: round-robin victim pointer plus saturating occupancy count.
//   clk_i        in   clock, rising edge
//   rst_i        in   asynchronous active-low reset
//   advance_i    in   one allocation happened this cycle
//   ptr_o        out  index the next allocation writes to
//   occupancy_o  out  entries allocated since reset, saturating at HEIGHT
module cam_alloc_ptr
    import cam_pkg::*;
#(
    parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
    parameter int HEIGHT     = CAM_HEIGHT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  advance_i,
    output logic [ADDR_WIDTH-1:0] ptr_o,
    output logic [ADDR_WIDTH:0]   occupancy_o
);

    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(HEIGHT - 1);
    localparam logic [ADDR_WIDTH:0]   OCC_MAX  = (ADDR_WIDTH + 1)'(HEIGHT);

    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   occ_q, occ_d;

    always_comb begin
        ptr_d = ptr_q;
        occ_d = occ_q;
        if (advance_i) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + ADDR_WIDTH'(1);
            // once full, allocations overwrite the oldest entry; count holds
            if (occ_q != OCC_MAX) occ_d = occ_q + (ADDR_WIDTH + 1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr_q <= '0;
            occ_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            occ_q <= occ_d;
        end
    end

    assign ptr_o       = ptr_q;
    assign occupancy_o = occ_q;

endmodule

// File: rtl/cam_lookup_ctrl.sv
// cam_lookup_ctrl: initiator-side controller for one cam instance.
//   Takes a key lookup on req_*, searches the CAM, optionally allocates the
//   key at a round-robin victim on a miss, and returns hit/alloc/index on rsp_*.
//   req_valid_i/req_ready_o/req_key_i/req_alloc_i : lookup request
//   rsp_valid_o/rsp_ready_i/rsp_hit_o/rsp_alloc_o/rsp_index_o : response
//   occupancy_o          : entries allocated since reset, saturating at HEIGHT
//   cam_write_*_o        : CAM write port (one-cycle pulse per allocation)
//   cam_search_*_o       : CAM search port (one-cycle pulse per lookup)
//   cam_search_valid_i/index_i : CAM search result, one cycle after the search
// All cam_* and rsp_* outputs, and req_ready_o, come straight from flops.
module cam_lookup_ctrl
    import cam_pkg::*;
#(
    parameter int WIDTH      = CAM_WIDTH,
    parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
    parameter int HEIGHT     = CAM_HEIGHT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [WIDTH-1:0]      req_key_i,
    input  logic                  req_alloc_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_hit_o,
    output logic                  rsp_alloc_o,
    output logic [ADDR_WIDTH-1:0] rsp_index_o,
    output logic [ADDR_WIDTH:0]   occupancy_o,
    output logic                  cam_write_enable_o,
    output logic [ADDR_WIDTH-1:0] cam_write_index_o,
    output logic [WIDTH-1:0]      cam_write_data_o,
    output logic                  cam_search_enable_o,
    output logic [WIDTH-1:0]      cam_search_data_o,
    input  logic                  cam_search_valid_i,
    input  logic [ADDR_WIDTH-1:0] cam_search_index_i
);

    cam_ctrl_state_t state_q, state_d;

    logic [WIDTH-1:0]      key_q, key_d;
    logic                  alloc_q, alloc_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_hit_q, rsp_hit_d;
    logic                  rsp_alloc_q, rsp_alloc_d;
    logic [ADDR_WIDTH-1:0] rsp_index_q, rsp_index_d;
    logic                  cam_we_q, cam_we_d;
    logic [ADDR_WIDTH-1:0] cam_wi_q, cam_wi_d;
    logic [WIDTH-1:0]      cam_wd_q, cam_wd_d;
    logic                  cam_se_q, cam_se_d;
    logic [WIDTH-1:0]      cam_sd_q, cam_sd_d;

    logic [ADDR_WIDTH-1:0] victim;

    cam_alloc_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .HEIGHT     (HEIGHT)
    ) u_alloc_ptr (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .advance_i   (state_q == WRITE),
        .ptr_o       (victim),
        .occupancy_o (occupancy_o)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = SEARCH;
            SEARCH:  state_d = WAIT;
            WAIT:    state_d = (!cam_search_valid_i && alloc_q) ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are computed from the state being
    // entered (state_d) and land in the same cycle as that state.
    always_comb begin
        key_d       = key_q;
        alloc_d     = alloc_q;
        req_ready_d = (state_d == IDLE);
        cam_se_d    = (state_d == SEARCH);
        cam_sd_d    = '0;
        cam_we_d    = (state_d == WRITE);
        cam_wi_d    = '0;
        cam_wd_d    = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_alloc_d = rsp_alloc_q;
        rsp_index_d = rsp_index_q;

        if (state_q == IDLE && req_valid_i) begin
            key_d   = req_key_i;
            alloc_d = req_alloc_i;
        end
        // SEARCH is only entered on the accept edge, before key_q is loaded
        if (state_d == SEARCH) cam_sd_d = req_key_i;
        if (state_d == WRITE) begin
            cam_wi_d = victim;
            cam_wd_d = key_q;
        end

        case (state_q)
            WAIT: if (state_d == RESP) begin
                rsp_valid_d = 1'b1;
                rsp_hit_d   = cam_search_valid_i;
                rsp_alloc_d = 1'b0;
                rsp_index_d = cam_search_valid_i ? cam_search_index_i : '0;
            end
            WRITE: begin
                rsp_valid_d = 1'b1;
                rsp_hit_d   = 1'b0;
                rsp_alloc_d = 1'b1;
                rsp_index_d = victim;  // pointer advances on this same edge
            end
            RESP: if (rsp_ready_i) begin
                rsp_valid_d = 1'b0;
                rsp_hit_d   = 1'b0;
                rsp_alloc_d = 1'b0;
                rsp_index_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            key_q       <= '0;
            alloc_q     <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_alloc_q <= 1'b0;
            rsp_index_q <= '0;
            cam_we_q    <= 1'b0;
            cam_wi_q    <= '0;
            cam_wd_q    <= '0;
            cam_se_q    <= 1'b0;
            cam_sd_q    <= '0;
        end else begin
            key_q       <= key_d;
            alloc_q     <= alloc_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_alloc_q <= rsp_alloc_d;
            rsp_index_q <= rsp_index_d;
            cam_we_q    <= cam_we_d;
            cam_wi_q    <= cam_wi_d;
            cam_wd_q    <= cam_wd_d;
            cam_se_q    <= cam_se_d;
            cam_sd_q    <= cam_sd_d;
        end
    end

    assign req_ready_o         = req_ready_q;
    assign rsp_valid_o         = rsp_valid_q;
    assign rsp_hit_o           = rsp_hit_q;
    assign rsp_alloc_o         = rsp_alloc_q;
    assign rsp_index_o         = rsp_index_q;
    assign cam_write_enable_o  = cam_we_q;
    assign cam_write_index_o   = cam_wi_q;
    assign cam_write_data_o    = cam_wd_q;
    assign cam_search_enable_o = cam_se_q;
    assign cam_search_data_o   = cam_sd_q;

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// Bench for cam_lookup_ctrl with a 4-entry behavioural CAM on its cam_* ports.
module tb_cam_lookup_ctrl;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int H  = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [W-1:0]  req_key_i = '0;
    logic          req_alloc_i = 1'b0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic          rsp_hit_o;
    logic          rsp_alloc_o;
    logic [AW-1:0] rsp_index_o;
    logic [AW:0]   occupancy_o;
    logic          cam_write_enable_o;
    logic [AW-1:0] cam_write_index_o;
    logic [W-1:0]  cam_write_data_o;
    logic          cam_search_enable_o;
    logic [W-1:0]  cam_search_data_o;
    logic          cam_search_valid_i;
    logic [AW-1:0] cam_search_index_i;

    cam_lookup_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW), .HEIGHT(H)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .req_valid_i         (req_valid_i),
        .req_ready_o         (req_ready_o),
        .req_key_i           (req_key_i),
        .req_alloc_i         (req_alloc_i),
        .rsp_valid_o         (rsp_valid_o),
        .rsp_ready_i         (rsp_ready_i),
        .rsp_hit_o           (rsp_hit_o),
        .rsp_alloc_o         (rsp_alloc_o),
        .rsp_index_o         (rsp_index_o),
        .occupancy_o         (occupancy_o),
        .cam_write_enable_o  (cam_write_enable_o),
        .cam_write_index_o   (cam_write_index_o),
        .cam_write_data_o    (cam_write_data_o),
        .cam_search_enable_o (cam_search_enable_o),
        .cam_search_data_o   (cam_search_data_o),
        .cam_search_valid_i  (cam_search_valid_i),
        .cam_search_index_i  (cam_search_index_i)
    );

    always #5 clk_i = ~clk_i;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural CAM (environment) ----------------
    logic [W-1:0] cm_key [H];
    logic [H-1:0] cm_v;
    int           wr_cnt;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cm_v               <= '0;
            cam_search_valid_i <= 1'b0;
            cam_search_index_i <= '0;
            wr_cnt             <= 0;
        end else begin
            if (cam_write_enable_o) begin
                cm_key[cam_write_index_o[1:0]] <= cam_write_data_o;
                cm_v[cam_write_index_o[1:0]]   <= 1'b1;
                wr_cnt                         <= wr_cnt + 1;
            end
            cam_search_valid_i <= 1'b0;
            cam_search_index_i <= '0;
            if (cam_search_enable_o)
                for (int i = H - 1; i >= 0; i--)
                    if (cm_v[i] && cm_key[i] == cam_search_data_o) begin
                        cam_search_valid_i <= 1'b1;
                        cam_search_index_i <= AW'(i);
                    end
        end
    end

    // ---------------- transaction-level reference + per-cycle compare ----------------
    // A request accepted in cycle 0 searches in cycle 1, writes in cycle 3 if it
    // allocates, and responds from cycle 3 (lookup) or 4 (allocation) until taken.
    bit           seen;  // a clock edge has passed since reset release
    always @(posedge clk_i or negedge rst_i)
        if (!rst_i) seen <= 1'b0;
        else        seen <= 1'b1;

    logic [W-1:0] ref_key [H];
    logic [H-1:0] ref_v;
    int           ref_victim, ref_occ;
    int           n = 0, n0, d;
    bit           active;
    logic [W-1:0] t_key;
    bit           t_hit, t_allocd;
    int           t_idx, t_lat, occ_before;

    always @(negedge clk_i) begin
        n++;
        if (!rst_i) begin
            chk("rst_req_ready", 64'(req_ready_o), 64'(0));
            chk("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
            chk("rst_rsp_fields", 64'({rsp_hit_o, rsp_alloc_o, rsp_index_o}), 64'(0));
            chk("rst_occupancy", 64'(occupancy_o), 64'(0));
            chk("rst_cam_write", 64'({cam_write_enable_o, cam_write_index_o, cam_write_data_o}), 64'(0));
            chk("rst_cam_search", 64'({cam_search_enable_o, cam_search_data_o}), 64'(0));
            active     = 1'b0;
            ref_v      = '0;
            ref_victim = 0;
            ref_occ    = 0;
        end else begin
            chk("req_ready", 64'(req_ready_o), 64'(seen && !active));
            if (active) begin
                d = n - n0;
                chk("cam_search_enable", 64'(cam_search_enable_o), 64'(d == 1));
                if (d == 1) chk("cam_search_data", 64'(cam_search_data_o), 64'(t_key));
                chk("cam_write_enable", 64'(cam_write_enable_o), 64'(t_allocd && d == 3));
                if (t_allocd && d == 3) begin
                    chk("cam_write_index", 64'(cam_write_index_o), 64'(t_idx));
                    chk("cam_write_data", 64'(cam_write_data_o), 64'(t_key));
                end
                chk("rsp_valid", 64'(rsp_valid_o), 64'(d >= t_lat));
                if (d >= t_lat) begin
                    chk("rsp_hit", 64'(rsp_hit_o), 64'(t_hit));
                    chk("rsp_alloc", 64'(rsp_alloc_o), 64'(t_allocd));
                    chk("rsp_index", 64'(rsp_index_o), 64'(t_idx));
                end
                chk("occupancy", 64'(occupancy_o), 64'((t_allocd && d >= 4) ? ref_occ : occ_before));
                if (d >= t_lat && rsp_ready_i) active = 1'b0;
            end else begin
                chk("idle_cam_search", 64'(cam_search_enable_o), 64'(0));
                chk("idle_cam_write", 64'(cam_write_enable_o), 64'(0));
                chk("idle_rsp_valid", 64'(rsp_valid_o), 64'(0));
                chk("idle_occupancy", 64'(occupancy_o), 64'(ref_occ));
                if (seen && req_valid_i) begin
                    t_key = req_key_i;
                    t_hit = 1'b0;
                    t_idx = 0;
                    for (int i = 0; i < H; i++)
                        if (!t_hit && ref_v[i] && ref_key[i] == t_key) begin
                            t_hit = 1'b1;
                            t_idx = i;
                        end
                    t_allocd   = !t_hit && req_alloc_i;
                    occ_before = ref_occ;
                    if (t_allocd) begin
                        t_idx               = ref_victim;
                        ref_key[ref_victim] = t_key;
                        ref_v[ref_victim]   = 1'b1;
                        ref_victim          = (ref_victim + 1) % H;
                        if (ref_occ < H) ref_occ++;
                    end
                    t_lat  = t_allocd ? 4 : 3;
                    n0     = n;
                    active = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Inputs change only at posedge+1; the compare process samples at negedge.
    task automatic do_req(input logic [W-1:0] k, input bit a, input int hold,
                          output bit h, output bit al, output logic [AW-1:0] idx, output int lat);
        bit ok;
        req_valid_i = 1'b1;
        req_key_i   = k;
        req_alloc_i = a;
        if (hold <= 0) rsp_ready_i = 1'b1;
        ok = 1'b0;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk_i);
            if (req_ready_o) begin ok = 1'b1; break; end
        end
        chk("accept_timeout", 64'(ok), 64'(1));
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        req_key_i   = $urandom;       // must not disturb the captured key
        req_alloc_i = 1'($urandom);
        lat = 0;
        ok  = 1'b0;
        while (lat < 50 && !ok) begin
            @(negedge clk_i);
            lat++;
            ok = rsp_valid_o;
        end
        chk("rsp_timeout", 64'(ok), 64'(1));
        h   = rsp_hit_o;
        al  = rsp_alloc_o;
        idx = rsp_index_o;
        if (hold > 0) begin
            repeat (hold) @(posedge clk_i);
            #1 rsp_ready_i = 1'b1;
        end
        @(posedge clk_i); #1 rsp_ready_i = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk_i); #2 rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #2 rst_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    bit            h, al, ok;
    logic [AW-1:0] idx;
    int            lat, wr0;
    logic [W-1:0]  k4 [5];
    int            exp4 [5];
    logic [W-1:0]  pool [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp4 = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) k4[i] = 32'hA000_0000 + 32'(i * 17);

        // reset held from time 0
        repeat (3) @(negedge clk_i);
        #2 rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("t0_ready_after_release", 64'(req_ready_o), 64'(1));
        chk("t0_occupancy", 64'(occupancy_o), 64'(0));

        // 1: allocate on miss
        do_req(32'hDEAD_BEEF, 1'b1, 0, h, al, idx, lat);
        chk("t1_hit", 64'(h), 64'(0));
        chk("t1_alloc", 64'(al), 64'(1));
        chk("t1_index", 64'(idx), 64'(0));
        chk("t1_latency", 64'(lat), 64'(4));
        chk("t1_occupancy", 64'(occupancy_o), 64'(1));

        // 2: same key hits, alloc request is irrelevant, no write
        wr0 = wr_cnt;
        do_req(32'hDEAD_BEEF, 1'b1, 0, h, al, idx, lat);
        chk("t2_hit", 64'(h), 64'(1));
        chk("t2_alloc", 64'(al), 64'(0));
        chk("t2_index", 64'(idx), 64'(0));
        chk("t2_latency", 64'(lat), 64'(3));
        chk("t2_no_write", 64'(wr_cnt), 64'(wr0));

        // 3: plain miss
        do_req(32'h0000_1234, 1'b0, 0, h, al, idx, lat);
        chk("t3_hit", 64'(h), 64'(0));
        chk("t3_alloc", 64'(al), 64'(0));
        chk("t3_index", 64'(idx), 64'(0));
        chk("t3_latency", 64'(lat), 64'(3));
        chk("t3_occupancy", 64'(occupancy_o), 64'(1));
        chk("t3_no_write", 64'(wr_cnt), 64'(wr0));

        // 4: wrap and saturate with HEIGHT=4
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            do_req(k4[i], 1'b1, 0, h, al, idx, lat);
            chk("t4_alloc", 64'(al), 64'(1));
            chk("t4_index", 64'(idx), 64'(exp4[i]));
            chk("t4_occupancy", 64'(occupancy_o), 64'((i < 4) ? i + 1 : 4));
        end
        do_req(k4[0], 1'b0, 0, h, al, idx, lat);
        chk("t4_first_key_evicted", 64'(h), 64'(0));
        do_req(k4[4], 1'b0, 0, h, al, idx, lat);
        chk("t4_last_key_hit", 64'({h, idx}), 64'({1'b1, 5'd0}));

        // 5: response back-pressure for 10 cycles
        do_req(k4[2], 1'b0, 10, h, al, idx, lat);
        chk("t5_hit_index", 64'({h, al, idx}), 64'({1'b1, 1'b0, 5'd2}));

        // 6: reset while the write pulse is on the CAM port
        req_valid_i = 1'b1;
        req_key_i   = 32'hCAFE_0006;
        req_alloc_i = 1'b1;
        ok = 1'b0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk_i);
            if (req_ready_o) begin ok = 1'b1; break; end
        end
        chk("t6_accept", 64'(ok), 64'(1));
        @(posedge clk_i); #1 req_valid_i = 1'b0;
        ok = 1'b0;
        for (int w = 0; w < 10; w++) begin
            @(negedge clk_i);
            if (cam_write_enable_o) begin ok = 1'b1; break; end
        end
        chk("t6_write_seen", 64'(ok), 64'(1));
        #2 rst_i = 1'b0;
        #1;
        chk("t6_async_write_enable", 64'(cam_write_enable_o), 64'(0));
        chk("t6_async_rsp_valid", 64'(rsp_valid_o), 64'(0));
        chk("t6_async_occupancy", 64'(occupancy_o), 64'(0));
        chk("t6_async_req_ready", 64'(req_ready_o), 64'(0));
        repeat (2) @(negedge clk_i);
        #2 rst_i = 1'b1;
        @(posedge clk_i); #1;
        do_req(32'hCAFE_0007, 1'b1, 1, h, al, idx, lat);
        chk("t6_realloc", 64'({h, al, idx}), 64'({1'b0, 1'b1, 5'd0}));
        chk("t6_latency", 64'(lat), 64'(4));
        chk("t6_occupancy", 64'(occupancy_o), 64'(1));

        // random traffic over a small key pool so hits, misses and evictions mix
        for (int i = 0; i < 8; i++) pool[i] = $urandom;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk_i); #1 req_key_i = $urandom;
            end
            do_req(pool[$urandom_range(0, 7)], 1'($urandom), int'($urandom_range(0, 3)),
                   h, al, idx, lat);
        end

        repeat (3) @(posedge clk_i);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
